// File: rtl/wb_commit_pkg.sv
// Shared pipeline definitions: opcode groups, load funct3 codes, writeback FSM states.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
//
// Contents:
//   OPC_*        5-bit major opcodes (inst[6:2]).
//   F3_*         load funct3 codes.
//   wb_state_t   writeback FSM state encoding.
//   opc_writes_rd  true for opcodes that produce an rd result.
package wb_commit_pkg;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // Load funct3 codes, inst[14:12]
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_t;

  // Opcodes whose result lands in rd. Everything else (stores, branches,
  // fences, system, unknown) still retires but never writes the RF.
  function automatic logic opc_writes_rd(input logic [4:0] opc);
    logic w;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
      default:                      w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: picks the byte/half/word lane from the raw response and extends to DW.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   rdata    in  DW  raw load response word
//   funct3   in  3   load type
//   addr_lo  in  LW  low address bits selecting the byte lane
//   aligned  out DW  extended, lane-aligned result
module wb_load_align
  import wb_commit_pkg::*;
#(
  parameter  int DW = 32,
  localparam int LW = $clog2(DW / 8)
) (
  input  logic [DW-1:0] rdata,
  input  logic [2:0]    funct3,
  input  logic [LW-1:0] addr_lo,
  output logic [DW-1:0] aligned
);

  // Halfword and word lanes are the byte address with the low bits masked,
  // so one shift form serves all three sizes. For DW=32 the word mask
  // clears every bit and the word lane is always 0.
  localparam logic [LW-1:0] HALF_MASK = ~LW'(1);
  localparam logic [LW-1:0] WORD_MASK = ~LW'(3);
  localparam bit            IS64      = (DW == 64);

  logic [DW-1:0] sh_b;
  logic [DW-1:0] sh_h;
  logic [DW-1:0] sh_w;

  assign sh_b = rdata >> {addr_lo, 3'b000};
  assign sh_h = rdata >> {addr_lo & HALF_MASK, 3'b000};
  assign sh_w = rdata >> {addr_lo & WORD_MASK, 3'b000};

  // Sized casts of signed operands sign-extend; of unsigned, zero-extend.
  always_comb begin
    aligned = rdata;
    case (funct3)
      F3_LB:  aligned = DW'($signed(sh_b[7:0]));
      F3_LBU: aligned = DW'(sh_b[7:0]);
      F3_LH:  aligned = DW'($signed(sh_h[15:0]));
      F3_LHU: aligned = DW'(sh_h[15:0]);
      F3_LW:  aligned = DW'($signed(sh_w[31:0]));
      F3_LWU: if (IS64) aligned = DW'(sh_w[31:0]);
      F3_LD:  aligned = rdata;
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: decodes rd-writing ops, waits for load data, drives a registered RF write port.
// Latency: non-load commits 1 cycle after accept; load commits 1 cycle after the dmem_rvalid cycle.
// Backpressure: in_ready is low only while a load waits for its response; otherwise 1 instr/cycle.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              upstream handshake
//   in_inst, in_rd, in_result      instruction word, destination, non-load result
//   in_addr_lo                     low load-address bits (byte lane)
//   dmem_rvalid, dmem_rdata        load response
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   retire_cnt                     committed-instruction counter (wraps)
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter  int RFW = 5,
  parameter  int DW  = 32,
  parameter  int IW  = 32,
  parameter  int CW  = 32,
  localparam int LW  = $clog2(DW / 8)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_inst,
  input  logic [RFW-1:0] in_rd,
  input  logic [DW-1:0]  in_result,
  input  logic [LW-1:0]  in_addr_lo,
  input  logic           dmem_rvalid,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           rf_we,
  output logic [RFW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic [CW-1:0]  retire_cnt
);

  wb_state_t      state_q;
  wb_state_t      state_d;

  logic [4:0]     opc;
  logic [2:0]     funct3;
  logic           is_load;
  logic           writes;

  // Load context captured at accept, consumed when the response arrives.
  logic [RFW-1:0] ld_rd_q;
  logic [2:0]     ld_f3_q;
  logic [LW-1:0]  ld_addr_q;
  logic [DW-1:0]  ld_aligned;

  logic           rf_we_d;
  logic [RFW-1:0] rf_waddr_d;
  logic [DW-1:0]  rf_wdata_d;
  logic           commit;
  logic           load_acc;

  logic           unused_inst_bits;

  assign opc     = in_inst[6:2];
  assign funct3  = in_inst[14:12];
  assign is_load = (opc == OPC_LOAD);
  assign writes  = opc_writes_rd(opc);

  // rd travels on its own port; the remaining instruction fields are not needed here.
  assign unused_inst_bits = ^{in_inst[IW-1:15], in_inst[11:7], in_inst[1:0]};

  wb_load_align #(.DW(DW)) u_align (
    .rdata   (dmem_rdata),
    .funct3  (ld_f3_q),
    .addr_lo (ld_addr_q),
    .aligned (ld_aligned)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (in_valid && is_load) state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: if (dmem_rvalid)         state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshake plus the next values of the registered write port.
  // Address/data hold their last value on cycles with no commit.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    commit     = 1'b0;
    load_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_load) begin
            load_acc = 1'b1;
          end else begin
            commit     = 1'b1;
            rf_we_d    = writes && (in_rd != '0);
            rf_waddr_d = in_rd;
            rf_wdata_d = in_result;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          commit     = 1'b1;
          rf_we_d    = (ld_rd_q != '0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = ld_aligned;
        end
      end
      default: ;
    endcase
  end

  // Write port, retire counter and load context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      retire_cnt <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_addr_q  <= '0;
    end else begin
      rf_we    <= rf_we_d;
      rf_waddr <= rf_waddr_d;
      rf_wdata <= rf_wdata_d;
      if (commit) retire_cnt <= retire_cnt + CW'(1);
      if (load_acc) begin
        ld_rd_q   <= in_rd;
        ld_f3_q   <= funct3;
        ld_addr_q <= in_addr_lo;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: default config, CW=4 wrap variant, DW=64 alignment variant.
// Inputs change and outputs are sampled on the falling edge.
module tb_wb_commit;
  import wb_commit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        in_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;

  logic        rdy_c4, we_c4;
  logic [4:0]  waddr_c4;
  logic [31:0] wdata_c4;
  logic [3:0]  cnt_c4;

  logic        v64, rv64, rdy64, we64;
  logic [31:0] inst64;
  logic [4:0]  rd64, waddr64;
  logic [63:0] res64, rdata64, wdata64;
  logic [2:0]  addr64;
  logic [31:0] cnt64;

  int n_checks = 0;
  int n_errors = 0;

  wb_commit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rd(in_rd), .in_result(in_result), .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  wb_commit #(.CW(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c4),
    .in_inst(in_inst), .in_rd(in_rd), .in_result(in_result), .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(we_c4), .rf_waddr(waddr_c4), .rf_wdata(wdata_c4), .retire_cnt(cnt_c4)
  );

  wb_commit #(.DW(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
    .in_inst(inst64), .in_rd(rd64), .in_result(res64), .in_addr_lo(addr64),
    .dmem_rvalid(rv64), .dmem_rdata(rdata64),
    .rf_we(we64), .rf_waddr(waddr64), .rf_wdata(wdata64), .retire_cnt(cnt64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc, 2'b11};
  endfunction

  // Present one instruction for exactly one edge; it is always accepted
  // because every caller starts from IDLE.
  task automatic send(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] res, input logic [1:0] addr);
    in_valid   = 1'b1;
    in_inst    = mk_inst(opc, f3);
    in_rd      = rd;
    in_result  = res;
    in_addr_lo = addr;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  // Called in the first cycle after a load accept. Checks in_ready stays low
  // for n cycles, with the response presented in the last of them.
  task automatic respond(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("ready_low_in_wait", 64'(in_ready), 64'd0);
      if (i == n - 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = data;
      end
      @(negedge clk);
    end
    dmem_rvalid = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_we"}, 64'(rf_we), 64'(we));
    if (we) begin
      check_eq({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
      check_eq({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
    end
  endtask

  task automatic ld64(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [2:0] addr, input logic [63:0] data, input logic [63:0] exp);
    v64    = 1'b1;
    inst64 = mk_inst(OPC_LOAD, f3);
    rd64   = rd;
    addr64 = addr;
    @(negedge clk);
    v64 = 1'b0;
    check_eq({tag, "_ready_low"}, 64'(rdy64), 64'd0);
    rv64    = 1'b1;
    rdata64 = data;
    @(negedge clk);
    rv64 = 1'b0;
    check_eq({tag, "_we"}, 64'(we64), 64'd1);
    check_eq({tag, "_waddr"}, 64'(waddr64), 64'(rd));
    check_eq({tag, "_wdata"}, wdata64, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_rd = '0; in_result = '0; in_addr_lo = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    v64 = 1'b0; rv64 = 1'b0; inst64 = '0; rd64 = '0; res64 = '0; rdata64 = '0; addr64 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ready",    64'(in_ready),   64'd1);
    check_eq("rst_we",       64'(rf_we),      64'd0);
    check_eq("rst_waddr",    64'(rf_waddr),   64'd0);
    check_eq("rst_wdata",    64'(rf_wdata),   64'd0);
    check_eq("rst_cnt",      64'(retire_cnt), 64'd0);
    check_eq("rst_ready64",  64'(rdy64),      64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back ALU ops
    send(OPC_OP, 3'b000, 5'd5, 32'h0000_1234, 2'd0);
    expect_wr("add", 1'b1, 5'd5, 32'h0000_1234);
    check_eq("b2b_ready", 64'(in_ready), 64'd1);
    send(OPC_OP_IMM, 3'b000, 5'd6, 32'hFFFF_FFFF, 2'd0);
    expect_wr("addi", 1'b1, 5'd6, 32'hFFFF_FFFF);
    check_eq("b2b_ready2", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_eq("b2b_we_drop", 64'(rf_we), 64'd0);
    check_eq("b2b_cnt", 64'(retire_cnt), 64'd2);

    // 2: LB with a 3-cycle wait, top byte 0x80 sign-extends
    send(OPC_LOAD, F3_LB, 5'd7, 32'h0, 2'd3);
    respond(32'h80AA_BBCC, 3);
    expect_wr("lb", 1'b1, 5'd7, 32'hFFFF_FF80);
    check_eq("lb_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_eq("lb_we_pulse", 64'(rf_we), 64'd0);
    check_eq("lb_cnt", 64'(retire_cnt), 64'd3);

    // 3: LHU upper halfword
    send(OPC_LOAD, F3_LHU, 5'd8, 32'h0, 2'd2);
    respond(32'h8001_0002, 1);
    expect_wr("lhu", 1'b1, 5'd8, 32'h0000_8001);

    // 4: non-writing and rd=0 commits
    send(OPC_STORE, 3'b010, 5'd9, 32'h0000_AAAA, 2'd0);
    expect_wr("store", 1'b0, 5'd0, 32'h0);
    check_eq("store_cnt", 64'(retire_cnt), 64'd5);
    send(OPC_OP, 3'b000, 5'd0, 32'h0000_0055, 2'd0);
    expect_wr("add_x0", 1'b0, 5'd0, 32'h0);
    check_eq("add_x0_cnt", 64'(retire_cnt), 64'd6);
    send(OPC_LOAD, F3_LW, 5'd0, 32'h0, 2'd0);
    respond(32'h1234_5678, 2);
    expect_wr("lw_x0", 1'b0, 5'd0, 32'h0);
    check_eq("lw_x0_ready", 64'(in_ready), 64'd1);
    check_eq("lw_x0_cnt", 64'(retire_cnt), 64'd7);

    // More lanes and extensions
    send(OPC_LOAD, F3_LH, 5'd10, 32'h0, 2'd0);
    respond(32'h1234_8765, 1);
    expect_wr("lh", 1'b1, 5'd10, 32'hFFFF_8765);
    send(OPC_LOAD, F3_LD, 5'd11, 32'h0, 2'd1);
    respond(32'hDEAD_BEEF, 1);
    expect_wr("ld_illegal32", 1'b1, 5'd11, 32'hDEAD_BEEF);
    send(OPC_LOAD, F3_LW, 5'd12, 32'h0, 2'd0);
    respond(32'h8000_0001, 1);
    expect_wr("lw32", 1'b1, 5'd12, 32'h8000_0001);
    send(OPC_LOAD, F3_LBU, 5'd13, 32'h0, 2'd1);
    respond(32'h1234_F0AB, 2);
    expect_wr("lbu", 1'b1, 5'd13, 32'h0000_00F0);
    send(OPC_JAL, 3'b000, 5'd1, 32'h0000_0104, 2'd0);
    expect_wr("jal", 1'b1, 5'd1, 32'h0000_0104);
    send(OPC_BRANCH, 3'b001, 5'd3, 32'h0000_0001, 2'd0);
    expect_wr("branch", 1'b0, 5'd0, 32'h0);
    check_eq("mix_cnt", 64'(retire_cnt), 64'd13);
    check_eq("mix_cnt_c4", 64'(cnt_c4), 64'd13);

    // 5: reset while a load is pending
    send(OPC_LOAD, F3_LW, 5'd4, 32'h0, 2'd0);
    check_eq("pre_rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_cnt", 64'(retire_cnt), 64'd0);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq("midrst_no_we", 64'(rf_we), 64'd0);
    check_eq("midrst_ready2", 64'(in_ready), 64'd1);
    check_eq("midrst_cnt2", 64'(retire_cnt), 64'd0);

    // 6: 17 back-to-back commits wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check_eq("wrap_c4_at16", 64'(cnt_c4), 64'd0);
      check_eq("wrap_ready", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_inst   = mk_inst(OPC_OP_IMM, 3'b000);
      in_rd     = 5'd1;
      in_result = 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    expect_wr("wrap_last", 1'b1, 5'd1, 32'd16);
    check_eq("wrap_c4", 64'(cnt_c4), 64'd1);
    check_eq("wrap_cnt32", 64'(retire_cnt), 64'd17);

    // DW=64 alignment
    ld64("lwu64", F3_LWU, 5'd2, 3'd4, 64'hF000_0001_0000_0002, 64'h0000_0000_F000_0001);
    ld64("ld64",  F3_LD,  5'd3, 3'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    ld64("lw64",  F3_LW,  5'd4, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    ld64("lb64",  F3_LB,  5'd5, 3'd7, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F);
    ld64("lhu64", F3_LHU, 5'd6, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    ld64("lh64",  F3_LH,  5'd7, 3'd6, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
    ld64("f3_111", 3'b111, 5'd8, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    check_eq("cnt64", 64'(cnt64), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
